// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl -- hazard and sequencing controller for the F/D/E/W pipeline
//
// Drives the 2-bit update strobes of the three pipeline stage registers
// (01 = advance, 10 = flush to bubble, 00 = hold) and the PC enable.
// Multi-cycle execute instructions, load-use hazards, taken branch/jump
// redirects and stop/resume halts are sequenced by a three-state FSM
// (RUN, EXEC_WAIT, HALT) plus a down-counter for the extra execute cycles.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the 32-bit stall and
// flush performance counters. Without it both counter outputs are tied to 0
// and no counter flops exist.
//
// Parameters:
//   WAIT_W        width of the execute wait-time field
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   d_rs, d_rt    decode sources: [5] register bank, [4:0] register index
//   de_rw         write class of the execute instruction (0 = no write,
//                 [1] = destination bank)
//   de_rd         destination index of the execute instruction
//   de_is_load    execute instruction is a memory load
//   de_wait_time  extra execute cycles needed by the execute instruction
//   de_stop       execute instruction is a stop
//   e_redirect    taken branch/jump resolves in execute this cycle
//   resume        single-cycle pulse that leaves HALT
//   fd_update     fetch/decode register control
//   de_update     decode/execute register control
//   ew_update     execute/writeback register control
//   pc_en         PC register may load its next value
//   halted        high while the FSM is in HALT
//   stall_cnt     cycles with pc_en low while not halted (perf build only)
//   flush_cnt     number of redirect flushes (perf build only)
// ============================================================================
module pipe_ctrl #(
    parameter int WAIT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        d_rs,
    input  logic [5:0]        d_rt,
    input  logic [1:0]        de_rw,
    input  logic [4:0]        de_rd,
    input  logic              de_is_load,
    input  logic [WAIT_W-1:0] de_wait_time,
    input  logic              de_stop,
    input  logic              e_redirect,
    input  logic              resume,
    output logic [1:0]        fd_update,
    output logic [1:0]        de_update,
    output logic [1:0]        ew_update,
    output logic              pc_en,
    output logic              halted,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_EXEC_WAIT = 2'd1,
        S_HALT      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;

    // Unmasked controls; the outputs force them to hold while rst is high.
    logic [1:0]         fd_upd_c, de_upd_c, ew_upd_c;
    logic               pc_en_c;

    logic               e_done;
    logic               hz_rs, hz_rt, load_use;

    // ------------------------------------------------------------------
    // Hazard detection. Conservative: register 0 is not excluded, so a
    // load targeting r0 still costs a bubble if decode reads r0.
    // ------------------------------------------------------------------
    always_comb begin
        hz_rs    = (de_rw[1] == d_rs[5]) && (de_rd == d_rs[4:0]);
        hz_rt    = (de_rw[1] == d_rt[5]) && (de_rd == d_rt[4:0]);
        load_use = de_is_load && (de_rw != 2'b00) && (hz_rs || hz_rt);
    end

    // The execute instruction finishes this cycle: either it needed no
    // extra cycles, or the wait counter has run out.
    always_comb begin
        e_done = ((state_q == S_RUN) && (de_wait_time == '0)) ||
                 ((state_q == S_EXEC_WAIT) && (cnt_q == '0));
    end

    // ------------------------------------------------------------------
    // Next-state and stage-control decision, first match wins.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fd_upd_c = UPD_HOLD;
        de_upd_c = UPD_HOLD;
        ew_upd_c = UPD_HOLD;
        pc_en_c  = 1'b0;

        if (state_q == S_HALT) begin
            // Everything frozen; the first advance comes one cycle after
            // the FSM is back in RUN.
            if (resume) begin
                state_d = S_RUN;
            end
        end else if ((state_q == S_RUN) && (de_wait_time != '0)) begin
            // First extra execute cycle: hold F/D/E, feed a bubble into W.
            // W extra cycles plus the completing cycle give W+1 in execute.
            ew_upd_c = UPD_FLUSH;
            state_d  = S_EXEC_WAIT;
            cnt_d    = de_wait_time - WAIT_W'(1);
        end else if ((state_q == S_EXEC_WAIT) && (cnt_q != '0)) begin
            ew_upd_c = UPD_FLUSH;
            cnt_d    = cnt_q - WAIT_W'(1);
        end else if (e_done && de_stop) begin
            // Let the stop retire, squash the younger instructions.
            ew_upd_c = UPD_ADV;
            de_upd_c = UPD_FLUSH;
            fd_upd_c = UPD_FLUSH;
            state_d  = S_HALT;
        end else if (e_done && e_redirect) begin
            // Two wrong-path instructions in F/D and D/E are squashed while
            // the PC loads the branch/jump target.
            ew_upd_c = UPD_ADV;
            de_upd_c = UPD_FLUSH;
            fd_upd_c = UPD_FLUSH;
            pc_en_c  = 1'b1;
            state_d  = S_RUN;
        end else if (e_done && load_use) begin
            // Keep the dependent instruction in decode for one cycle and
            // put a bubble behind the load.
            ew_upd_c = UPD_ADV;
            de_upd_c = UPD_FLUSH;
            fd_upd_c = UPD_HOLD;
            state_d  = S_RUN;
        end else begin
            ew_upd_c = UPD_ADV;
            de_upd_c = UPD_ADV;
            fd_upd_c = UPD_ADV;
            pc_en_c  = 1'b1;
            state_d  = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The stage registers sit in their own reset, so hold everything
    // (and keep the PC still) for as long as rst is asserted.
    assign fd_update = rst ? UPD_HOLD : fd_upd_c;
    assign de_update = rst ? UPD_HOLD : de_upd_c;
    assign ew_update = rst ? UPD_HOLD : ew_upd_c;
    assign pc_en     = rst ? 1'b0     : pc_en_c;
    assign halted    = (state_q == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, free-running and wrapping modulo 2^32.
    // A stall is any non-halted cycle where the PC does not move; a flush
    // event is the redirect case, the only one with pc_en high and F/D
    // being squashed.
    // ------------------------------------------------------------------
    logic        stall_evt, flush_evt;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_evt   = !pc_en_c && (state_q != S_HALT);
        flush_evt   = pc_en_c && (fd_upd_c == UPD_FLUSH);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_evt) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl
//
// A table of per-cycle input vectors with expected stage controls drives the
// main sequence; expected values are pushed to a scoreboard queue when a
// vector is driven and popped when the outputs are sampled on the falling
// edge. Hand-written sequences cover asynchronous reset during EXEC_WAIT and
// during HALT.
// ============================================================================
module tb_pipe_ctrl;

    localparam int WAIT_W = 5;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Packed expected outputs: {fd_update, de_update, ew_update, pc_en, halted}
    localparam logic [7:0] O_RUN   = 8'b01_01_01_1_0;
    localparam logic [7:0] O_STALL = 8'b00_00_10_0_0;
    localparam logic [7:0] O_LU    = 8'b00_10_01_0_0;
    localparam logic [7:0] O_FLUSH = 8'b10_10_01_1_0;
    localparam logic [7:0] O_STOP  = 8'b10_10_01_0_0;
    localparam logic [7:0] O_HALT  = 8'b00_00_00_0_1;
    localparam logic [7:0] O_RST   = 8'b00_00_00_0_0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [5:0]        d_rs = '0;
    logic [5:0]        d_rt = '0;
    logic [1:0]        de_rw = '0;
    logic [4:0]        de_rd = '0;
    logic              de_is_load = 1'b0;
    logic [WAIT_W-1:0] de_wait_time = '0;
    logic              de_stop = 1'b0;
    logic              e_redirect = 1'b0;
    logic              resume = 1'b0;
    logic [1:0]        fd_update, de_update, ew_update;
    logic              pc_en, halted;
    logic [31:0]       stall_cnt, flush_cnt;

    pipe_ctrl #(.WAIT_W(WAIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .de_rw        (de_rw),
        .de_rd        (de_rd),
        .de_is_load   (de_is_load),
        .de_wait_time (de_wait_time),
        .de_stop      (de_stop),
        .e_redirect   (e_redirect),
        .resume       (resume),
        .fd_update    (fd_update),
        .de_update    (de_update),
        .ew_update    (ew_update),
        .pc_en        (pc_en),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [5:0]        rs;
        logic [5:0]        rt;
        logic [1:0]        rw;
        logic [4:0]        rd;
        logic              ld;
        logic [WAIT_W-1:0] wt;
        logic              stop;
        logic              redir;
        logic              res;
        logic [7:0]        outs;
    } vec_t;

    typedef struct {
        string       name;
        logic [7:0]  outs;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic vec_t mk(string n, logic [5:0] rs, logic [5:0] rt,
                                logic [1:0] rw, logic [4:0] rd, logic ld,
                                logic [WAIT_W-1:0] wt, logic stop,
                                logic redir, logic res, logic [7:0] o);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.rw = rw; v.rd = rd; v.ld = ld;
        v.wt = wt; v.stop = stop; v.redir = redir; v.res = res; v.outs = o;
        return v;
    endfunction

    function automatic logic [31:0] outs_now();
        return 32'({fd_update, de_update, ew_update, pc_en, halted});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Called just after a rising edge: apply one cycle of inputs and queue
    // what the outputs and counters must show in that cycle.
    task automatic drive(input vec_t v);
        exp_t e;
        d_rs = v.rs; d_rt = v.rt; de_rw = v.rw; de_rd = v.rd;
        de_is_load = v.ld; de_wait_time = v.wt; de_stop = v.stop;
        e_redirect = v.redir; resume = v.res;
        e.name = v.name;
        e.outs = v.outs;
        e.sc   = PERF ? m_stall : 32'd0;
        e.fc   = PERF ? m_flush : 32'd0;
        exp_q.push_back(e);
        // Counters are registered: this cycle's event shows up next cycle.
        if (v.outs[1] == 1'b0 && v.outs[0] == 1'b0) m_stall++;
        if (v.outs == O_FLUSH) m_flush++;
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: actual=0 required=1");
            return;
        end
        e = exp_q.pop_front();
        chk({e.name, "_outs"}, outs_now(), 32'(e.outs));
        chk({e.name, "_stall"}, stall_cnt, e.sc);
        chk({e.name, "_flush"}, flush_cnt, e.fc);
    endtask

    task automatic idle_vec(output vec_t v, input string n, input logic [7:0] o);
        v = mk(n, 6'h00, 6'h00, 2'b00, 5'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, o);
    endtask

    initial begin
        vec_t v;

        //           name           rs     rt     rw     rd   ld  wt  stop redir res outs
        tbl.push_back(mk("idle0",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("idle1",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("wait3_a", 6'h00, 6'h00, 2'b00, 5'd0, 0, 3, 0, 0, 0, O_STALL));
        tbl.push_back(mk("wait3_rd",6'h00, 6'h00, 2'b00, 5'd0, 0, 3, 0, 1, 0, O_STALL));
        tbl.push_back(mk("wait3_c", 6'h00, 6'h00, 2'b00, 5'd0, 0, 3, 0, 0, 0, O_STALL));
        tbl.push_back(mk("wait3_d", 6'h00, 6'h00, 2'b00, 5'd0, 0, 3, 0, 0, 0, O_RUN));
        tbl.push_back(mk("lu_rs",   6'h07, 6'h00, 2'b01, 5'd7, 1, 0, 0, 0, 0, O_LU));
        tbl.push_back(mk("lu_bank", 6'h27, 6'h00, 2'b01, 5'd7, 1, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("lu_rt",   6'h01, 6'h23, 2'b10, 5'd3, 1, 0, 0, 0, 0, O_LU));
        tbl.push_back(mk("lu_nowr", 6'h07, 6'h00, 2'b00, 5'd7, 1, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("lu_nold", 6'h07, 6'h00, 2'b01, 5'd7, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("redir",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 1, 0, O_FLUSH));
        tbl.push_back(mk("redir_lu",6'h07, 6'h00, 2'b01, 5'd7, 1, 0, 0, 1, 0, O_FLUSH));
        tbl.push_back(mk("stop",    6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 1, 0, 0, O_STOP));
        tbl.push_back(mk("halt_ign",6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 1, 1, 0, O_HALT));
        tbl.push_back(mk("halt2",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_HALT));
        tbl.push_back(mk("resume",  6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 1, O_HALT));
        tbl.push_back(mk("post_res",6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("res_run", 6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 1, O_RUN));
        tbl.push_back(mk("wait1_a", 6'h00, 6'h00, 2'b00, 5'd0, 0, 1, 0, 0, 0, O_STALL));
        tbl.push_back(mk("wait1_st",6'h00, 6'h00, 2'b00, 5'd0, 0, 1, 1, 0, 0, O_STOP));
        tbl.push_back(mk("halt3",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 1, O_HALT));
        tbl.push_back(mk("run3",    6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk("w2_st_a", 6'h00, 6'h00, 2'b00, 5'd0, 0, 2, 1, 0, 0, O_STALL));
        tbl.push_back(mk("w2_st_b", 6'h00, 6'h00, 2'b00, 5'd0, 0, 2, 1, 0, 0, O_STALL));
        tbl.push_back(mk("w2_c",    6'h00, 6'h00, 2'b00, 5'd0, 0, 2, 0, 0, 0, O_RUN));
        tbl.push_back(mk("idle2",   6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 0, 0, 0, O_RUN));

        // Reset state while rst is held.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_outs", outs_now(), 32'(O_RST));
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check_pop();
            @(posedge clk);
            #1;
        end

        // Async reset in the middle of EXEC_WAIT with cnt = 4.
        v = mk("ew5_a", 6'h00, 6'h00, 2'b00, 5'd0, 0, 5, 0, 0, 0, O_STALL);
        drive(v);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
        v = mk("ew5_b", 6'h00, 6'h00, 2'b00, 5'd0, 0, 5, 0, 0, 0, O_STALL);
        drive(v);
        @(negedge clk);
        check_pop();
        chk("ew5_cnt4", 32'(dut.cnt_q), 32'd4);
        #2 rst = 1'b1;
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("ew_rst_outs", outs_now(), 32'(O_RST));
        chk("ew_rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("ew_rst_stall", stall_cnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_vec(v, "ew_rel", O_RUN);
        drive(v);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;

        // Async reset while halted.
        v = mk("h_stop", 6'h00, 6'h00, 2'b00, 5'd0, 0, 0, 1, 0, 0, O_STOP);
        drive(v);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
        idle_vec(v, "h_halt", O_HALT);
        drive(v);
        @(negedge clk);
        check_pop();
        #2 rst = 1'b1;
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("h_rst_outs", outs_now(), 32'(O_RST));
        @(posedge clk);
        #1 rst = 1'b0;
        idle_vec(v, "h_rel", O_RUN);
        drive(v);
        @(negedge clk);
        check_pop();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
